// File: rtl/apb_pkg.sv
// Shared types for the APB memory slave: FSM state, error classification,
// pprot bit positions and the debug view of the slave's internal state.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_st_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_PROT  = 2'd3
    } apb_err_e;

    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    // Wait-state counter width; WAIT_STATES is limited to 0..15.
    localparam int WCNT_W = 4;

    // Debug view: FSM state, remaining wait cycles, and the error class of
    // whatever address/pprot is currently on the bus.
    typedef struct packed {
        apb_slv_st_e        st;
        logic [WCNT_W-1:0]  wcnt;
        apb_err_e           err;
    } apb_slv_dbg_t;

endpackage

// File: rtl/apb_slv_mem.sv
// Single-port DEPTH x DATA_WIDTH storage for the APB slave.
// Writes are synchronous with one enable per byte lane; the read port is
// combinational and is sampled into prdata by the slave FSM.
// Contents are deliberately not reset.
module apb_slv_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Byte-lane write: only lanes with their enable set are updated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB leaf slave backed by a byte-strobed local memory.
// Optional pprot-based protection of the low PROT_DEPTH words is enabled by
// defining the macro APB_SLV_PROT_EN; without it pprot is ignored.
//
// Handshake: a transfer is accepted when psel=1 and penable=0 (SETUP) while
// the FSM is IDLE. The slave completes it in the first ACCESS cycle where
// pready=1; the completion edge is the rising edge where psel, penable and
// pready are all high. pslverr is meaningful only while pready=1. Dropping
// psel during ACCESS aborts the transfer without a write or an error.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int PROT_DEPTH  = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output apb_slv_dbg_t            dbg
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [AW1-1:0]        DEPTH_L    = AW1'(DEPTH);

    apb_slv_st_e           st_q, st_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  align_err;
    logic                  range_err;
    logic                  prot_err;
    logic                  setup_err;
    apb_err_e              err_kind;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Address decode for the SETUP-phase checks.
    assign word_idx  = paddr >> LSB;
    assign align_err = |(paddr & ALIGN_MASK);
    assign range_err = {1'b0, word_idx} >= DEPTH_L;

`ifdef APB_SLV_PROT_EN
    localparam logic [AW1-1:0] PROT_L = AW1'(PROT_DEPTH);
    logic unused_instr;
    assign unused_instr = pprot[PPROT_INSTR];
    // Protected words need a privileged, secure access.
    assign prot_err = ({1'b0, word_idx} < PROT_L) &&
                      !(pprot[PPROT_PRIV] && !pprot[PPROT_NSEC]);
`else
    logic unused_prot;
    assign unused_prot = ^{pprot, 32'(PROT_DEPTH)};
    assign prot_err    = 1'b0;
`endif

    assign setup_err = align_err | range_err | prot_err;

    // Classify the current bus address for the debug view.
    always_comb begin
        err_kind = ERR_NONE;
        if (align_err)      err_kind = ERR_ALIGN;
        else if (range_err) err_kind = ERR_RANGE;
        else if (prot_err)  err_kind = ERR_PROT;
    end

    apb_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (pclk),
        .addr  (word_idx[IDX_W-1:0]),
        .be    (mem_be),
        .wdata (pwdata),
        .rdata (mem_rdata)
    );

    // State register: FSM, wait counter, latched error and read data.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            st_q     <= IDLE;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            st_q     <= st_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
        end
    end

    // Next state: accept SETUP in IDLE, count waits, finish or abort in ACCESS.
    always_comb begin
        st_d     = st_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        unique case (st_q)
            IDLE: begin
                if (psel && !penable) begin
                    st_d   = ACCESS;
                    wcnt_d = WCNT_W'(WAIT_STATES);
                    err_d  = setup_err;
                    if (!pwrite) begin
                        prdata_d = setup_err ? '0 : mem_rdata;
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    st_d   = IDLE;
                    wcnt_d = '0;
                    err_d  = 1'b0;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else if (penable) begin
                    st_d  = IDLE;
                    err_d = 1'b0;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Outputs: ready/error from state, byte enables on the completion edge.
    always_comb begin
        pready  = (st_q == ACCESS) && (wcnt_q == '0);
        pslverr = pready && err_q;
        mem_be  = '0;
        if (pready && psel && penable && pwrite && !err_q) begin
            mem_be = pstrb;
        end
    end

    assign prdata = prdata_q;
    assign dbg    = '{st: st_q, wcnt: wcnt_q, err: err_kind};

endmodule
